// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: captures pipeline register writes with cycle stamps, then dumps and drains them
// Ports: clk/reset (async, active-low); wb_e/wb_a/wb_d writeback capture; pc_out end-of-program watch;
//        dump one-cycle pulse into the pipeline; out_valid/out_ready/out_cycle/out_rd/out_data trace drain;
//        count FIFO occupancy; overflow/drop_cnt lost-entry status; timed_out end cause; done end state.
module wb_trace_buffer #(
  parameter int DEPTH        = 16,
  parameter int PC_LIMIT     = 150,
  parameter int TIMEOUT      = 200,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wb_e,
  input  logic [4:0]                 wb_a,
  input  logic [31:0]                wb_d,
  input  logic [31:0]                pc_out,
  output logic                       dump,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                out_cycle,
  output logic [4:0]                 out_rd,
  output logic [31:0]                out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt,
  output logic                       timed_out,
  output logic                       done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  typedef enum logic [1:0] {RUN, FLUSH, DRAIN, DONE} state_e;
  state_e state_q, state_d;
  logic [15:0] cyc_q, cyc_d;
  logic [FW-1:0] fl_q, fl_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0] drop_q, drop_d;
  logic ovf_q, ovf_d, timed_q, timed_d, dump_q, dump_d;
  logic [52:0] mem_q [DEPTH];
  logic capturing, capture, full, push, drop, pop, pc_hit, to_hit;
  assign capturing = (state_q == RUN) || (state_q == FLUSH);
  assign capture   = capturing && wb_e && (wb_a != 5'd0);
  assign full      = count_q == CW'(DEPTH);
  assign push      = capture && !full;
  assign drop      = capture && full;
  assign out_valid = (state_q == DRAIN) && (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign pc_hit    = pc_out >= 32'(PC_LIMIT);
  assign to_hit    = cyc_q == 16'(TIMEOUT - 1);
  assign {out_cycle, out_rd, out_data} = (count_q != '0) ? mem_q[rd_q] : 53'd0;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;
  assign timed_out = timed_q;
  assign dump      = dump_q;
  assign done      = state_q == DONE;
  always_comb begin
    cyc_d   = (capturing && cyc_q != 16'hFFFF) ? cyc_q + 16'd1 : cyc_q;
    wr_d    = push ? wr_q + AW'(1) : wr_q;
    rd_d    = pop ? rd_q + AW'(1) : rd_q;
    count_d = count_q + CW'(push) - CW'(pop);
    ovf_d   = ovf_q | drop;
    drop_d  = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    state_d = state_q;
    fl_d    = fl_q;
    timed_d = timed_q;
    dump_d  = 1'b0;
    case (state_q)
      RUN: if (pc_hit || to_hit) begin
        state_d = FLUSH;
        fl_d    = '0;
        // a PC-limit hit in the same cycle takes precedence over the timeout
        timed_d = timed_q | !pc_hit;
      end
      FLUSH: if (fl_q == FW'(FLUSH_CYCLES - 1)) begin
        state_d = DRAIN;
        dump_d  = 1'b1;
      end else begin
        fl_d = fl_q + FW'(1);
      end
      // no pushes in DRAIN, so the next count reflects only this cycle's pop
      DRAIN: state_d = (count_d == '0) ? DONE : DRAIN;
      default: state_d = DONE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cyc_q   <= '0;
      fl_q    <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
      timed_q <= 1'b0;
      dump_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      fl_q    <= fl_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      timed_q <= timed_d;
      dump_q  <= dump_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {cyc_q, wb_a, wb_d};
  end
endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
- Sits directly downstream of riscv_pipeline and consumes its writeback port (wb_e/wb_a/wb_d) and pc_out.
- Records every architectural register write with a cycle stamp in a FIFO.
- Detects end-of-program (PC limit) or a timeout, waits for the pipeline to flush, then pulses dump into the pipeline.
- Finally drains the recorded trace through a valid/ready port to a checker or scoreboard.

Parameters:
- DEPTH, 16: FIFO entries; power of two, ≥2.
- PC_LIMIT, 150: end-of-program trigger when pc_out ≥ PC_LIMIT (unsigned).
- TIMEOUT, 200: end trigger when the cycle counter reaches TIMEOUT in RUN.
- FLUSH_CYCLES, 4: cycles of continued capture after a trigger, before dump.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset.
- wb_e  in  1  pipeline writeback enable.
- wb_a  in  5  writeback destination register.
- wb_d  in  32  writeback data.
- pc_out  in  32  pipeline fetch PC.
- dump  out  1  one-cycle pulse to pipeline register-dump input.
- out_valid  out  1  trace entry available, DRAIN state only.
- out_ready  in  1  consumer accepts entry.
- out_cycle  out  16  cycle stamp of head entry.
- out_rd  out  5  rd of head entry.
- out_data  out  32  data of head entry.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; a push was dropped while full.
- drop_cnt  out  8  dropped pushes, saturates at 255.
- timed_out  out  1  sticky; end was caused by timeout.
- done  out  1  high in DONE state.

Behaviour:
- Reset (async assert, sync release): state=RUN, FIFO empty. All outputs 0: dump, out_valid, count, overflow, drop_cnt, timed_out, done. out_* data fields 0. cyc=0, flush counter=0.
- cyc: 16-bit counter, +1 every clock in RUN and FLUSH, saturates at 0xFFFF, frozen in DRAIN/DONE. The first post-reset capture is stamped 0.
- Capture, RUN and FLUSH only:
  - Push condition is wb_e && wb_a≠0. x0 writes are never recorded.
  - Entry = {cyc, wb_a, wb_d}, sampled the same edge; count updates the next cycle.
- Full FIFO with a push condition:
  - The entry is discarded and the FIFO is unchanged.
  - overflow←1; drop_cnt+1, saturating.
- States:
  - RUN → FLUSH when pc_out ≥ PC_LIMIT, or when cyc == TIMEOUT-1 at the edge (then timed_out←1). If both hold the same cycle, the PC limit wins and timed_out stays 0.
  - FLUSH: counts FLUSH_CYCLES clocks while still capturing. On the last one → DRAIN, and dump=1 for exactly that one following cycle, the first DRAIN cycle.
  - DRAIN:
    - out_valid = (count≠0).
    - out_cycle/out_rd/out_data show the head entry combinationally from FIFO storage; they are 0 when empty.
    - out_valid && out_ready pops one entry per cycle.
    - Pipeline writebacks are ignored and not counted as drops.
    - Data must hold stable while valid && !ready.
  - DRAIN → DONE on the cycle count==0, evaluated after dump has pulsed, so the minimum DRAIN duration is 1 cycle.
  - DONE: absorbing until reset; done=1, out_valid=0.
- FIFO pointers: $clog2(DEPTH) bits and wrap at DEPTH. count is a separate register, 0..DEPTH.
- Reset mid-DRAIN or mid-FLUSH immediately returns to RUN with the FIFO emptied. dump deasserts asynchronously.
- No combinational path from wb_* to out_*.

Test Plan:
- Normal run: reset low 5 cycles. Inject wb writes (x5=0x11, x0=0x99, x6=0x22) at cyc 3, 4, 7, then pc_out=150 at cyc 10. Required: FLUSH cycles 11–14, dump=1 at the cycle-15 DRAIN entry. Drain with out_ready=1 returns exactly (3,5,0x11) then (7,6,0x22); x0 absent. done=1 the cycle after the last pop, timed_out=0.
- Overflow: push 20 consecutive x1 writes, data 1..20, with DEPTH=16. Required: count=16, overflow=1, drop_cnt=4; drain yields data 1..16 in order.
- Timeout: pc_out held at 0. Required: timed_out=1 and FLUSH entered after cyc reaches 199; dump pulses FLUSH_CYCLES later; empty FIFO goes to done=1 one cycle after dump.
- Backpressure: 3 entries in DRAIN, out_ready toggling 0,1,0,0,1,1. Required: out_* stable while stalled; pops occur only on ready cycles; count sequence 3,2,2,2,1,0.
- Capture during FLUSH, ignore in DRAIN: a write of x9=0xAB during FLUSH appears in the trace. A write of x9=0xCD during DRAIN appears neither in the trace nor in drop_cnt.
- Async reset mid-DRAIN: assert reset between clock edges with 2 entries left. Required: count=0, out_valid=0, done=0, dump=0 immediately; after release, state is RUN and cyc restarts at 0.
